// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the width of the shared adder slice.
package nibble_add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add_seq_add_slice4.sv
// Purely combinational 4-bit ripple-carry slice built from full-adder equations.
module add_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  // Ripple the carry through four full adders, LSB first
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit slice processes one nibble per
// clock, LSB first, with a registered carry linking consecutive nibbles.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [SLICE_W-1:0] nib_a, nib_b, slice_s;
  logic               slice_co;
  logic               last_nib;

  // Select the current operand nibbles from the latched operands
  always_comb begin
    nib_a    = a_q[SLICE_W*idx_q +: SLICE_W];
    nib_b    = b_q[SLICE_W*idx_q +: SLICE_W];
    last_nib = (idx_q == IDX_W'(NSLICE - 1));
  end

  add_slice4 u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: latched operands, running carry, nibble index, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = slice_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: a 16-bit instance for the hand-computed
// vectors and an 8-bit instance for back-to-back operation with start held high.
module tb_nibble_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        start16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        ready16, busy16, done16, cout16;

  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        ready8, busy8, done8, cout8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nibble_add_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .ready (ready16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  nibble_add_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until done16 is seen; n = edges waited (bounded)
  task automatic wait_done16(output int n);
    n = 0;
    while (done16 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, busy_cnt, done_cnt, prev_done;
    logic [8:0] exp9;

    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_ready", 32'(ready16), 32'd1);
    chk("rst_busy",  32'(busy16),  32'd0);
    chk("rst_done",  32'(done16),  32'd0);
    chk("rst_sum",   32'(sum16),   32'h0);
    chk("rst_cout",  32'(cout16),  32'd0);
    #2 rst = 1'b0;
    step();

    // 1234 + 4321 = 5555, latency check
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("t1_busy_accept",  32'(busy16),  32'd1);
    chk("t1_ready_accept", 32'(ready16), 32'd0);
    wait_done16(n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_sum",   32'(sum16),   32'h5555);
    chk("t1_cout",  32'(cout16),  32'd0);
    chk("t1_ready_in_done", 32'(ready16), 32'd0);
    chk("t1_busy_in_done",  32'(busy16),  32'd0);
    step();
    chk("t1_done_pulse", 32'(done16),  32'd0);
    chk("t1_ready_back", 32'(ready16), 32'd1);
    chk("t1_sum_held",   32'(sum16),   32'h5555);

    // FFFF + 0001: carry ripples through every slice
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    busy_cnt = 0;
    n = 0;
    while (done16 !== 1'b1 && n < 20) begin
      if (busy16 === 1'b1) busy_cnt++;
      step();
      n++;
    end
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("t2_sum",  32'(sum16),  32'h0000);
    chk("t2_cout", 32'(cout16), 32'd1);
    step();

    // FFFF + FFFF + 1, operands changed and start pulsed during RUN
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; start16 = 1'b1;
    step();
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    step();
    a16 = 16'h0001; b16 = 16'h0001; start16 = 1'b1;
    step();
    start16 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done16 === 1'b1) done_cnt++;
      step();
    end
    chk("t3_done_count", 32'(done_cnt), 32'd1);
    chk("t3_sum",  32'(sum16),  32'hFFFF);
    chk("t3_cout", 32'(cout16), 32'd1);
    chk("t3_ready", 32'(ready16), 32'd1);

    // Asynchronous reset in the second RUN cycle
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    chk("t5_sum_partial", 32'(sum16), 32'h0005);
    rst = 1'b1;
    #1;
    chk("t5_rst_sum",   32'(sum16),   32'h0);
    chk("t5_rst_cout",  32'(cout16),  32'd0);
    chk("t5_rst_ready", 32'(ready16), 32'd1);
    chk("t5_rst_busy",  32'(busy16),  32'd0);
    chk("t5_rst_done",  32'(done16),  32'd0);
    #1 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done16 === 1'b1) done_cnt++;
    end
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    wait_done16(n);
    chk("t5_latency", 32'(n), 32'd4);
    chk("t5_sum",  32'(sum16),  32'h0100);
    chk("t5_cout", 32'(cout16), 32'd0);
    step();

    // WIDTH=8, start held high: back-to-back random operations
    start8 = 1'b1;
    prev_done = -1;
    for (int i = 0; i < 50; i++) begin
      n = 0;
      while (ready8 !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      chk("w8_ready", 32'(ready8), 32'd1);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
      exp9 = 9'(a8) + 9'(b8) + 9'(cin8);
      step();
      wait_done8(n);
      chk("w8_latency", 32'(n), 32'd2);
      chk("w8_result", 32'({cout8, sum8}), 32'(exp9));
      if (prev_done >= 0) chk("w8_done_period", 32'(cyc - prev_done), 32'd4);
      prev_done = cyc;
      step();
    end
    start8 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
